// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 (CPOL=0, CPHA=0) bit shifter sitting below the spi_master FSM.
// Latency: done pulses in the cycle starting 2*CLK_DIV*N edges after the start edge (N = num_bits, 0 -> 32).
// Backpressure: none; start is sampled only in IDLE, so requests made while busy are dropped, not queued.
//
// Ports:
//   clk, reset_n      system clock (posedge) and asynchronous active-low reset
//   start             transfer request, accepted only when idle
//   num_bits[4:0]     transfer length, 0 encodes 32
//   tx_data[31:0]     right-aligned tx word; bit num_bits-1 is shifted out first
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle pulse; rx_data is valid from this cycle on
//   rx_data[31:0]     right-aligned received word, upper bits zero
//   SPICLK            serial clock, idles low
//   SPIMOSI           serial data out, holds its last bit between transfers
//   SPIMISO           serial data in, sampled on the SPICLK rising edge
//   loopback          present only with SPI_LOOPBACK_EN defined; samples SPIMOSI instead of SPIMISO
//
// Build option: define SPI_LOOPBACK_EN to add the 'loopback' input.
module spi_shift_engine #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [4:0]  num_bits,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data,
  output logic        SPICLK,
  output logic        SPIMOSI,
`ifdef SPI_LOOPBACK_EN
  input  logic        loopback,
`endif
  input  logic        SPIMISO
);

  // Half-period counter counts down from CLK_DIV-1 to 0 in each timed state.
  localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LOAD = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;
  logic [31:0]   tx_sh_q, tx_sh_d;
  logic [31:0]   rx_sh_q, rx_sh_d;
  logic [31:0]   rx_data_q, rx_data_d;
  logic          sclk_q, sclk_d;
  logic          done_q, done_d;

  logic [5:0]    n_eff;
  logic [5:0]    lshift;
  logic          sample_bit;
  logic [31:0]   rx_shifted;
  logic          div_zero;

  // 0 encodes a full 32-bit word.
  assign n_eff  = (num_bits == 5'd0) ? 6'd32 : {1'b0, num_bits};
  assign lshift = 6'd32 - n_eff;

  // MOSI is the top bit of the tx shift register, so it is valid from the
  // accept edge and naturally holds the last bit once shifting stops.
`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? tx_sh_q[31] : SPIMISO;
`else
  assign sample_bit = SPIMISO;
`endif

  assign rx_shifted = {rx_sh_q[30:0], sample_bit};
  assign div_zero   = (div_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Left-align so the first bit to send sits at bit 31.
          tx_sh_d   = tx_data << lshift;
          bit_cnt_d = n_eff;
          rx_sh_d   = '0;
          div_d     = DIV_LOAD;
          sclk_d    = 1'b0;
          state_d   = ST_LEAD;
        end
      end

      ST_LEAD: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          rx_sh_d = rx_shifted;
          div_d   = DIV_LOAD;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q - DW'(1);
        end
      end

      ST_HIGH: begin
        if (div_zero) begin
          bit_cnt_d = bit_cnt_q - 6'd1;
          sclk_d    = 1'b0;
          if (bit_cnt_q == 6'd1) begin
            // Last bit already sampled on this HIGH entry; publish the word.
            done_d    = 1'b1;
            rx_data_d = rx_sh_q;
            state_d   = ST_DONE;
          end else begin
            tx_sh_d = {tx_sh_q[30:0], 1'b0};
            div_d   = DIV_LOAD;
            state_d = ST_LOW;
          end
        end else begin
          div_d = div_q - DW'(1);
        end
      end

      ST_LOW: begin
        if (div_zero) begin
          sclk_d  = 1'b1;
          rx_sh_d = rx_shifted;
          div_d   = DIV_LOAD;
          state_d = ST_HIGH;
        end else begin
          div_d = div_q - DW'(1);
        end
      end

      ST_DONE: begin
        sclk_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        sclk_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign SPICLK  = sclk_q;
  assign SPIMOSI = tx_sh_q[31];

endmodule
